// File: rtl/btn_pkg.sv
// Shared button constants: channel indices and the default debounce depth.
package btn_pkg;

   localparam int RIGHT  = 0;
   localparam int LEFT   = 1;
   localparam int UP     = 2;
   localparam int DOWN   = 3;
   localparam int A      = 4;
   localparam int B      = 5;
   localparam int SELECT = 6;
   localparam int START  = 7;

   localparam int STABLE_CNT_DEF = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: input synchronizer, agreement counter, level and events.
// Event pulses exist only when BTN_EVENT_PULSE_EN is defined; otherwise tied to 0.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int STABLE_CNT = STABLE_CNT_DEF,
   parameter int CNT_WIDTH  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic raw,
   output logic level,
   output logic press,
   output logic drop
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CNT - 1);

   logic [1:0]           sync;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 differ;
   logic                 accept;

   assign differ = sync[1] != level;
   assign accept = strobe && differ && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (strobe) begin
            if (!differ) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               cnt   <= '0;
               level <= ~level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef BTN_EVENT_PULSE_EN
   // Pulses are registered so they line up with the level change.
   always_ff @(posedge clk) begin
      if (rst) begin
         press <= 1'b0;
         drop  <= 1'b0;
      end else begin
         press <= accept & ~level;
         drop  <= accept & level;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign press = 1'b0;
   assign drop  = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer sampled by a shared strobe from a slow tick.
// Press/release pulses are enabled by defining BTN_EVENT_PULSE_EN.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_BTN      = 8,
   parameter int STABLE_CNT = STABLE_CNT_DEF,
   parameter int CNT_WIDTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_state,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   // [1:0] synchronize tick, [2] holds the previous synchronized value.
   // Reset to all ones so a tick already high at release is not an edge.
   logic [2:0] tsync;
   logic       strobe;

   always_ff @(posedge clk) begin
      if (rst) begin
         tsync  <= 3'b111;
         strobe <= 1'b0;
      end else begin
         tsync  <= {tsync[1:0], tick};
         strobe <= tsync[1] & ~tsync[2];
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .STABLE_CNT (STABLE_CNT),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .strobe (strobe),
         .raw    (btn_raw[i]),
         .level  (btn_state[i]),
         .press  (btn_press[i]),
         .drop   (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: cycle model of the debounce rules plus directed scenarios.
module tb_btn_debounce;

   localparam int NB = 8;
   localparam int SC = 4;
`ifdef BTN_EVENT_PULSE_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_state;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btn_debounce #(
      .N_BTN      (NB),
      .STABLE_CNT (SC),
      .CNT_WIDTH  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (btn_raw),
      .btn_state   (btn_state),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   task automatic chk(input string nm, input logic [NB-1:0] act,
                      input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: tick and raw samples taken at each edge; a strobe acts three
   // edges after the tick sample rises, a raw sample is seen two edges later.
   bit            th[4];
   logic [NB-1:0] rh[2];
   logic [NB-1:0] m_state, m_press, m_rel;
   int            m_cnt[NB];
   bit            mvalid = 1'b0;

   always @(posedge clk) begin
      bit stb;
      if (rst) begin
         th      = '{1'b1, 1'b1, 1'b1, 1'b1};
         rh      = '{'0, '0};
         m_state = '0;
         m_press = '0;
         m_rel   = '0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         mvalid  = 1'b1;
      end else begin
         stb     = th[2] & ~th[3];
         m_press = '0;
         m_rel   = '0;
         if (stb) begin
            for (int i = 0; i < NB; i++) begin
               if (rh[1][i] != m_state[i]) begin
                  m_cnt[i]++;
                  if (m_cnt[i] >= SC) begin
                     m_cnt[i] = 0;
                     if (m_state[i]) m_rel[i] = PE;
                     else m_press[i] = PE;
                     m_state[i] = ~m_state[i];
                  end
               end else begin
                  m_cnt[i] = 0;
               end
            end
         end
         th[3] = th[2];
         th[2] = th[1];
         th[1] = th[0];
         th[0] = tick;
         rh[1] = rh[0];
         rh[0] = btn_raw;
      end
   end

   // Per-cycle compare and event tallies used by the directed checks.
   int            pc[NB];
   int            rc[NB];
   int            snap_n = 0;
   logic [NB-1:0] snap_p = '0;
   logic [NB-1:0] snap_r = '0;

   initial begin
      foreach (pc[i]) begin
         pc[i] = 0;
         rc[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("state", btn_state, m_state);
         chk("press", btn_press, m_press);
         chk("release", btn_release, m_rel);
         chk("press_and_release", btn_press & btn_release, '0);
         for (int i = 0; i < NB; i++) begin
            pc[i] += int'(btn_press[i]);
            rc[i] += int'(btn_release[i]);
         end
         if ((btn_press | btn_release) != '0) begin
            snap_n++;
            snap_p = btn_press;
            snap_r = btn_release;
         end
      end
   end

   function automatic int sum_pc();
      int s = 0;
      for (int i = 0; i < NB; i++) s += pc[i];
      return s;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobes(input int n);
      repeat (n) begin
         tick = 1'b0;
         cyc(6);
         tick = 1'b1;
         cyc(6);
      end
   endtask

   int b0, b1, b2;

   initial begin
      tick    = 1'b1;
      rst     = 1'b1;
      btn_raw = 8'h10;
      cyc(10);
      rst = 1'b0;
      cyc(10);
      chk("reset_state_tick_high", btn_state, 8'h00);

      // Clean press on A: accepted on the 4th strobe only.
      b0 = pc[4];
      strobes(3);
      chk("press_before_4th", btn_state, 8'h00);
      chk("no_early_press", 8'(pc[4] - b0), 8'h00);
      strobes(1);
      chk("press_state", btn_state, 8'h10);
      chk("press_pulse_once", 8'(pc[4] - b0), 8'(PE));

      // Bounce on RIGHT: two strobes high, then back low.
      b0 = pc[0];
      btn_raw = 8'h11;
      strobes(2);
      btn_raw = 8'h10;
      strobes(3);
      chk("bounce_state", btn_state, 8'h10);
      chk("bounce_no_press", 8'(pc[0] - b0), 8'h00);

      btn_raw = 8'h80;
      strobes(4);
      chk("to_start_state", btn_state, 8'h80);

      // Release of START.
      b0 = rc[7];
      b1 = sum_pc();
      btn_raw = 8'h00;
      strobes(4);
      chk("release_state", btn_state, 8'h00);
      chk("release_pulse_once", 8'(rc[7] - b0), 8'(PE));
      chk("release_no_press", 8'(sum_pc() - b1), 8'h00);

      // Simultaneous press of RIGHT/LEFT with release of SELECT.
      btn_raw = 8'h40;
      strobes(4);
      chk("select_state", btn_state, 8'h40);
      b2 = snap_n;
      btn_raw = 8'h03;
      strobes(4);
      chk("simul_state", btn_state, 8'h03);
      chk("simul_one_cycle", 8'(snap_n - b2), 8'(PE));
      chk("simul_press", snap_p, PE ? 8'h03 : 8'h00);
      chk("simul_release", snap_r, PE ? 8'h40 : 8'h00);

      // Reset mid-count on UP discards three strobes of progress.
      btn_raw = 8'h00;
      strobes(4);
      chk("clear_state", btn_state, 8'h00);
      btn_raw = 8'h04;
      strobes(3);
      rst = 1'b1;
      cyc(3);
      chk("in_reset_state", btn_state, 8'h00);
      rst = 1'b0;
      cyc(3);
      b0 = pc[2];
      strobes(3);
      chk("after_reset_3", btn_state, 8'h00);
      chk("after_reset_no_press", 8'(pc[2] - b0), 8'h00);
      strobes(1);
      chk("after_reset_4", btn_state, 8'h04);
      chk("after_reset_press", 8'(pc[2] - b0), 8'(PE));

      cyc(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
